// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-anode multi-digit
//             FND. Walks the digit commons one at a time and presents the
//             selected nibble to the downstream fnd_decoder, with dead-time
//             between digits, optional leading-zero blanking and frame-aligned
//             (tear-free) value updates.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1            system clock, rising edge
//    rst        in   1            synchronous active-high reset
//    load       in   1            strobe: capture value into pending register
//    value      in   4*DIGITS     packed nibbles, nibble i = value[4i+3:4i]
//    lz_blank   in   1            leading-zero blanking enable
//    dp_mask    in   DIGITS       decimal-point enable per digit
//    bcd        out  4            nibble of the scanned digit
//    com_n      out  DIGITS       active-low digit commons (at most one low)
//    dp_n       out  1            active-low decimal point
//    digit_idx  out  clog2(DIGITS) index of the scanned digit
//    frame_tick out  1            pulse on the last cycle of each frame
// ============================================================================
module fnd_scan_ctrl #(
  parameter  int DIGITS   = 8,
  parameter  int SCAN_DIV = 10000,
  parameter  int DEAD     = 16,
  localparam int DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     com_n,
  output logic                  dp_n,
  output logic [DW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [SW-1:0] c_SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] c_DEAD       = SW'(DEAD);
  localparam logic [DW-1:0] c_DIGIT_LAST = DW'(DIGITS - 1);

  // Counter and value state
  logic [SW-1:0]         r_slot;
  logic [DW-1:0]         r_digit;
  logic [4*DIGITS-1:0]   r_pending;
  logic [4*DIGITS-1:0]   r_active;

  // Output registers
  logic [3:0]            r_bcd;
  logic [DIGITS-1:0]     r_com_n;
  logic                  r_dp_n;
  logic                  r_frame_tick;

  // Next-state view of the counters; the output registers are loaded from
  // these so every output lines up with the counter state of its own cycle.
  logic                  w_slot_wrap;
  logic                  w_frame_end;
  logic [SW-1:0]         w_slot_nxt;
  logic [DW-1:0]         w_digit_nxt;
  logic [4*DIGITS-1:0]   w_active_nxt;
  logic [DIGITS-1:0]     w_zero_from;
  logic                  w_blank;
  logic                  w_lit;
  logic [DIGITS-1:0]     w_com_n_nxt;
  logic                  w_dp_n_nxt;
  logic [3:0]            w_bcd_nxt;
  logic                  w_frame_tick_nxt;

  assign w_slot_wrap = (r_slot == c_SLOT_LAST);
  assign w_frame_end = w_slot_wrap && (r_digit == c_DIGIT_LAST);
  assign w_slot_nxt  = w_slot_wrap ? '0 : r_slot + 1'b1;
  assign w_digit_nxt = !w_slot_wrap              ? r_digit :
                       (r_digit == c_DIGIT_LAST) ? '0      : r_digit + 1'b1;

  // The active value only moves at a frame boundary; a load landing exactly
  // on the boundary goes straight to the display instead of waiting a frame.
  assign w_active_nxt = !w_frame_end ? r_active :
                        load         ? value    : r_pending;

  // w_zero_from[i]: nibbles i..DIGITS-1 of the next active value are all zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero_from
    assign w_zero_from[gi] = (w_active_nxt[4*DIGITS-1:4*gi] == '0);
  end

  assign w_blank = lz_blank && (w_digit_nxt != '0) && w_zero_from[w_digit_nxt];
  assign w_lit   = (w_slot_nxt >= c_DEAD) && !w_blank;

  always_comb begin
    w_com_n_nxt = '1;
    if (w_lit) begin
      w_com_n_nxt[w_digit_nxt] = 1'b0;
    end
  end

  assign w_dp_n_nxt       = !(w_lit && dp_mask[w_digit_nxt]);
  assign w_bcd_nxt        = w_active_nxt[{w_digit_nxt, 2'b00} +: 4];
  assign w_frame_tick_nxt = (w_digit_nxt == c_DIGIT_LAST) && (w_slot_nxt == c_SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot       <= '0;
      r_digit      <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      r_bcd        <= '0;
      r_com_n      <= '1;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_slot       <= w_slot_nxt;
      r_digit      <= w_digit_nxt;
      r_active     <= w_active_nxt;
      if (load) begin
        r_pending  <= value;
      end
      r_bcd        <= w_bcd_nxt;
      r_com_n      <= w_com_n_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end
  end

  assign bcd        = r_bcd;
  assign com_n      = r_com_n;
  assign dp_n       = r_dp_n;
  assign digit_idx  = r_digit;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_ctrl
//  Purpose  : Directed self-checking bench for fnd_scan_ctrl with DIGITS=4,
//             SCAN_DIV=8, DEAD=2 (32-cycle frames). cyc counts cycles since
//             the last reset release; cycle 0 is the first cycle with rst low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        lz_blank = 1'b0;
  logic [3:0]  dp_mask = 4'b0000;
  logic [3:0]  bcd;
  logic [3:0]  com_n;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lz_blank   (lz_blank),
    .dp_mask    (dp_mask),
    .bcd        (bcd),
    .com_n      (com_n),
    .dp_n       (dp_n),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // ---------------- reference model of the outputs for cycle c ------------
  function automatic logic [3:0] m_com(input logic [15:0] v, input logic lz, input int c);
    int   s = c % SCAN_DIV;
    int   d = (c / SCAN_DIV) % DIGITS;
    logic blank = lz && (d != 0) && ((v >> (4 * d)) == 16'h0000);
    logic [3:0] one = 4'b0001;
    return (s >= DEAD && !blank) ? ~(one << d) : 4'b1111;
  endfunction

  // {bcd, com_n, dp_n, digit_idx, frame_tick}
  function automatic logic [11:0] m_out(input logic [15:0] v, input logic lz,
                                        input logic [3:0] dpm, input int c);
    int          d   = (c / SCAN_DIV) % DIGITS;
    logic [15:0] sh  = v >> (4 * d);
    logic [3:0]  com = m_com(v, lz, c);
    logic        dpn = !((com != 4'b1111) && dpm[d]);
    logic        ft  = ((c % FRAME) == FRAME - 1);
    return {sh[3:0], com, dpn, 2'(d), ft};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_frame_start;
    while (cyc % FRAME != 0) tick();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset;
    int early = 0;
    logic [3:0] exp_com;
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({com_n, dp_n, bcd, frame_tick} !== {4'b1111, 1'b1, 4'h0, 1'b0})
      $display("FAIL reset_hold got com_n=%b dp_n=%b bcd=%h ft=%b want 1111 1 0 0",
               com_n, dp_n, bcd, frame_tick);
    else n_pass++;
    tick();
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c <= 2) begin
        exp_com = (c == 2) ? 4'b1110 : 4'b1111;
        n_total++;
        if (com_n !== exp_com)
          $display("FAIL reset_release c=%0d got com_n=%b want %b", c, com_n, exp_com);
        else n_pass++;
      end
      if (c < FRAME - 1 && frame_tick === 1'b1) early++;
      if (c == FRAME - 1) begin
        n_total++;
        if (frame_tick !== 1'b1)
          $display("FAIL first_frame_tick c=31 got %b want 1", frame_tick);
        else n_pass++;
        n_total++;
        if (early !== 0)
          $display("FAIL early_frame_tick got %0d pulses want 0", early);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_scan_order;
    int lit[4] = '{0, 0, 0, 0};
    int multi = 0;
    logic [3:0] seen[4];
    logic [3:0] want_seq[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [11:0] exp;
    to_frame_start();
    lz_blank = 1'b0;
    dp_mask  = 4'b0000;
    pulse_load(16'h4321);
    to_frame_start();
    for (int k = 0; k < FRAME; k++) begin
      exp = m_out(16'h4321, 1'b0, 4'b0000, cyc);
      n_total++;
      if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
        $display("FAIL scan k=%0d got %h want %h", k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
      else n_pass++;
      for (int d = 0; d < 4; d++) if (com_n[d] === 1'b0) lit[d]++;
      if ($countones(~com_n) > 1) multi++;
      if (k % SCAN_DIV == 4) seen[k / SCAN_DIV] = bcd;
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (lit[d] !== 6) $display("FAIL scan_on_time digit=%0d got %0d want 6", d, lit[d]);
      else n_pass++;
      n_total++;
      if (seen[d] !== want_seq[d]) $display("FAIL scan_bcd_seq digit=%0d got %h want %h", d, seen[d], want_seq[d]);
      else n_pass++;
    end
    n_total++;
    if (multi !== 0) $display("FAIL scan_one_hot got %0d overlap cycles want 0", multi);
    else n_pass++;
  endtask

  task automatic test_lz_blank;
    logic [15:0] tv[4]    = '{16'h0050, 16'h0000, 16'h0050, 16'h0000};
    logic        tl[4]    = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  tmask[4] = '{4'b0011, 4'b0001, 4'b1111, 4'b1111};
    logic [3:0]  mask;
    logic [11:0] exp;
    for (int t = 0; t < 4; t++) begin
      to_frame_start();
      lz_blank = tl[t];
      pulse_load(tv[t]);
      to_frame_start();
      mask = 4'b0000;
      for (int k = 0; k < FRAME; k++) begin
        exp = m_out(tv[t], tl[t], 4'b0000, cyc);
        n_total++;
        if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
          $display("FAIL lz t=%0d k=%0d got %h want %h", t, k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
        else n_pass++;
        mask = mask | ~com_n;
        tick();
      end
      n_total++;
      if (mask !== tmask[t]) $display("FAIL lz_lit_digits t=%0d got %b want %b", t, mask, tmask[t]);
      else n_pass++;
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_tear_free;
    logic [11:0] exp;
    to_frame_start();
    pulse_load(16'h1234);
    to_frame_start();
    // Frame F: old value stays while two loads arrive
    for (int k = 0; k < FRAME; k++) begin
      exp = m_out(16'h1234, 1'b0, 4'b0000, cyc);
      n_total++;
      if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
        $display("FAIL tear_old k=%0d got %h want %h", k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
      else n_pass++;
      load = 1'b0;
      if (k == 0)  begin value = 16'hAAAA; load = 1'b1; end
      if (k == 12) begin value = 16'hBBBB; load = 1'b1; end
      tick();
    end
    load = 1'b0;
    // Frame F+1: last load wins; another load lands on the boundary cycle
    for (int k = 0; k < FRAME; k++) begin
      exp = m_out(16'hBBBB, 1'b0, 4'b0000, cyc);
      n_total++;
      if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
        $display("FAIL tear_new k=%0d got %h want %h", k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
      else n_pass++;
      if (k == FRAME - 1) begin value = 16'hCCCC; load = 1'b1; end
      tick();
    end
    load = 1'b0;
    // Frame F+2: boundary load shows immediately
    for (int k = 0; k < FRAME; k++) begin
      exp = m_out(16'hCCCC, 1'b0, 4'b0000, cyc);
      n_total++;
      if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
        $display("FAIL tear_boundary k=%0d got %h want %h", k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_dp;
    logic [15:0] tv[2]   = '{16'h4321, 16'h0001};
    logic        tl[2]   = '{1'b0, 1'b1};
    int          tcnt[2] = '{6, 0};
    int          low;
    int          stray;
    logic [11:0] exp;
    dp_mask = 4'b0100;
    for (int t = 0; t < 2; t++) begin
      to_frame_start();
      lz_blank = tl[t];
      pulse_load(tv[t]);
      to_frame_start();
      low = 0;
      stray = 0;
      for (int k = 0; k < FRAME; k++) begin
        exp = m_out(tv[t], tl[t], 4'b0100, cyc);
        n_total++;
        if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
          $display("FAIL dp t=%0d k=%0d got %h want %h", t, k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
        else n_pass++;
        if (dp_n === 1'b0) begin
          low++;
          if (com_n !== 4'b1011) stray++;
        end
        tick();
      end
      n_total++;
      if (low !== tcnt[t]) $display("FAIL dp_low_count t=%0d got %0d want %0d", t, low, tcnt[t]);
      else n_pass++;
      n_total++;
      if (stray !== 0) $display("FAIL dp_outside_digit2 t=%0d got %0d want 0", t, stray);
      else n_pass++;
    end
    dp_mask  = 4'b0000;
    lz_blank = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [11:0] exp;
    to_frame_start();
    pulse_load(16'h4321);
    to_frame_start();
    // Leave a different value pending so the reset has something to discard
    for (int k = 0; k < 21; k++) begin
      load = 1'b0;
      if (k == 3) begin value = 16'h9999; load = 1'b1; end
      tick();
    end
    load = 1'b0;
    n_total++;
    if ({digit_idx, com_n, bcd} !== {2'd2, 4'b1011, 4'h3})
      $display("FAIL midrst_pre got idx=%0d com_n=%b bcd=%h want 2 1011 3", digit_idx, com_n, bcd);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if ({com_n, dp_n, bcd, frame_tick, digit_idx} !== {4'b1111, 1'b1, 4'h0, 1'b0, 2'd0})
      $display("FAIL midrst_values got com_n=%b dp_n=%b bcd=%h ft=%b idx=%0d want 1111 1 0 0 0",
               com_n, dp_n, bcd, frame_tick, digit_idx);
    else n_pass++;
    rst = 1'b0;
    cyc = 0;
    // Two frames of an all-zero display: active cleared and pending discarded
    for (int k = 0; k < 2 * FRAME; k++) begin
      exp = m_out(16'h0000, 1'b0, 4'b0000, cyc);
      n_total++;
      if ({bcd, com_n, dp_n, digit_idx, frame_tick} !== exp)
        $display("FAIL midrst_after k=%0d got %h want %h", k, {bcd, com_n, dp_n, digit_idx, frame_tick}, exp);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_lz_blank();
    test_tear_free();
    test_dp();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit FND display. It holds a packed hex/BCD display value and walks the digit commons one at a time, presenting the selected digit's 4-bit code to the downstream `fnd_decoder` (`bcd` input) together with an active-low digit select and decimal point. It adds dead-time between digits against ghosting, optional leading-zero blanking, and tear-free value updates at frame boundaries.

## Interface

Parameters:
- `DIGITS`, 8: number of digits scanned; digit 0 is the least significant, rightmost digit.
- `SCAN_DIV`, 10000: clock cycles per digit slot; must be greater than `DEAD`.
- `DEAD`, 16: cycles at the start of each slot with all commons off; 0 disables dead-time.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `value` into the pending register.
- `value`  in  4*DIGITS  packed nibbles; nibble i is `value[4i+3:4i]`.
- `lz_blank`  in  1  leading-zero blanking enable; level-sensitive, sampled every cycle.
- `dp_mask`  in  DIGITS  bit i set lights the decimal point of digit i; sampled every cycle.
- `bcd`  out  4  nibble for the currently scanned digit; feeds `fnd_decoder.bcd`.
- `com_n`  out  DIGITS  active-low digit commons; at most one bit low at any time.
- `dp_n`  out  1  active-low decimal point for the scanned digit.
- `digit_idx`  out  clog2(DIGITS)  index of the digit currently scanned.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each full scan frame.

## Operation

- State: `slot_cnt` (0..SCAN_DIV-1), `digit_idx` (0..DIGITS-1), `pending` and `active` value registers (4*DIGITS each).
- `slot_cnt` increments every cycle and wraps SCAN_DIV-1 -> 0. On that wrap, `digit_idx` increments, and wraps DIGITS-1 -> 0.
- `load` writes `pending <= value`. `active` is the only register that drives the display.
- Frame boundary: the cycle where `digit_idx`=DIGITS-1 and `slot_cnt`=SCAN_DIV-1. On this edge `active <= pending`. If `load` is high in the same cycle, `active` takes `value` directly, bypassing `pending`.
- Digit i is blanked when all of the following hold:
  - `lz_blank`=1;
  - i != 0;
  - nibbles i..DIGITS-1 of `active` are all zero.
- Digit 0 is never blanked.
- `bcd` = `active` nibble `digit_idx`. It changes only at slot start (`slot_cnt`=0), which falls inside the dead-time.
- `com_n[digit_idx]` = 0 iff `slot_cnt` >= DEAD and the digit is not blanked. All other `com_n` bits are 1.
- `dp_n` = 0 iff its common is currently driven low and `dp_mask[digit_idx]`=1. Otherwise `dp_n` = 1.
- `frame_tick` is high only in the frame-boundary cycle.

## Timing

- All outputs are registered. Each output reflects the counter state of the current cycle; there is no extra pipeline stage.
- Reset values:
  - `slot_cnt`=0, `digit_idx`=0, `pending`=0, `active`=0;
  - `com_n` all ones, `bcd`=0, `dp_n`=1, `frame_tick`=0.
- First cycle after `rst` deasserts: digit 0, `slot_cnt`=0. Commons stay off for DEAD cycles.
- Per-digit on-time is SCAN_DIV-DEAD cycles. Frame length is DIGITS*SCAN_DIV cycles.
- Update latency: a `load` becomes visible at the first slot start after the next frame boundary. Worst case is DIGITS*SCAN_DIV+1 cycles.
- Multiple `load` strobes within one frame: the last one wins.
- `rst` asserted mid-frame: all state returns to reset values on the next edge. Pending data is discarded.
- `lz_blank` or `dp_mask` changing mid-slot takes effect on the next cycle.

## Test plan

Benches use DIGITS=4, SCAN_DIV=8, DEAD=2.

- Reset: hold `rst` 3 cycles, then release.
  - During reset: `com_n`=4'b1111, `dp_n`=1, `bcd`=0.
  - After release: `com_n`=4'b1110 from cycle 2, and `frame_tick` first pulses at cycle 31.
- Scan order: `load` `value`=16'h4321 and wait one frame. Next frame:
  - `bcd` sequence is 1,2,3,4;
  - each common is low for exactly 6 cycles, after 2 all-high cycles;
  - no two `com_n` bits are low in the same cycle.
- Leading-zero blanking: `value`=16'h0050, `lz_blank`=1.
  - Digits 3 and 2 are blanked (commons never low); digits 1 and 0 are lit with `bcd`=5 and `bcd`=0.
  - `value`=16'h0000 lights only digit 0.
  - Same values with `lz_blank`=0 light all four digits.
- Tear-free update: `load` 16'hAAAA at frame start, then `load` 16'hBBBB mid-frame.
  - The current frame keeps showing its old value.
  - The next frame shows B on all digits.
  - A `load` in the frame-boundary cycle is displayed in the very next frame.
- Decimal point: `dp_mask`=4'b0100.
  - `dp_n`=0 only during digit 2's on-time.
  - With `lz_blank`=1 and `value`=16'h0001, digit 2 is blanked and `dp_n` stays 1.
- Mid-operation reset: assert `rst` at digit 2, `slot_cnt`=5.
  - Next cycle: all outputs at reset values and `active`=0.
  - After release, scanning restarts at digit 0.
